spi_flash_reader: RTL
=====================

Name: spi_flash_reader

Overview:
- Bus-master sequencer directly upstream of the SPI peripheral; drives the peripheral's register interface to run SPI-flash READ (0x03) transactions.
- Accepts a read command (24-bit flash address, byte count) and emits the returned bytes as a valid/ready stream.
- Typical use: boot-image copy or XIP-style prefetch, without CPU register polling.

Parameters:
- BASE_ADDR, 32'h0, byte address of the SPI peripheral; registers at +0x00 TX, +0x04 RX, +0x08 CS, +0x0C CLKDIV, +0x10 BUSY.
- CLK_DIV, 16'd4, value written to CLKDIV at the start of every command.
- LEN_W, 16, width of the byte-count field.
- SETTLE, 3, idle cycles after a TX-write response before the first BUSY poll (min 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high only in IDLE
- cmd_addr_i  in  24  flash start address
- cmd_len_i  in  LEN_W  number of data bytes; 0 allowed
- data_valid_o  out  1  output byte valid
- data_o  out  8  output byte
- data_ready_i  in  1  consumer ready
- done_o  out  1  one-cycle pulse when the command completes (CS released)
- busy_o  out  1  high whenever not in IDLE
- m_req_valid_o  out  1  bus request to the SPI peripheral
- m_req_addr_o  out  32  BASE_ADDR + register offset
- m_req_value_o  out  32  write data (zero on reads)
- m_req_wstrb_o  out  4  4'hF for writes, 4'h0 for reads
- m_req_ready_i  in  1  peripheral accepts request
- m_resp_valid_i  in  1  response strobe
- m_resp_value_i  in  32  read data

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0 except cmd_ready_o=1; internal counters cleared.
- Bus rule: at most one outstanding request. m_req_valid_o and its addr/value/wstrb stay stable until m_req_ready_i is sampled high. The next request issues only after m_resp_valid_i for the previous one. A response arriving in the same cycle as the accept is legal.
- Handshake on cmd_valid_i && cmd_ready_o: latch addr and len, build header {0x03, A[23:16], A[15:8], A[7:0]}, go to SET_DIV.
- States and transitions:
  - IDLE: wait for command accept.
  - SET_DIV: write CLKDIV=CLK_DIV.
  - CS_LOW: write CS=0.
  - TX_WR: write TX = header byte (4 bytes), then 0x00 dummy for each data byte.
  - SETTLE: count SETTLE cycles.
  - POLL: read BUSY; value[0]=1 -> reissue POLL; value[0]=0 -> next step.
  - After POLL: header byte -> next TX_WR, or CS_HIGH if header is done and len==0. Data byte -> RX_RD.
  - RX_RD: read RX; capture m_resp_value_i[7:0] into data_o.
  - OUT: data_valid_o=1 until data_ready_i. Then the next data byte goes to TX_WR, or CS_HIGH if remaining==0.
  - CS_HIGH: write CS=1.
  - DONE: done_o=1 for one cycle, then IDLE.
- Byte counter: LEN_W bits, decremented on each OUT handshake; no wrap. Maximum len is 2^LEN_W-1.
- Back-pressure: data_o and data_valid_o are held stable while data_ready_i=0; no further bus requests issue.
- Header bytes produce no output and no RX read.
- cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).
- Reset mid-operation: immediate return to IDLE. CS release relies on the peripheral sharing the same reset.
- A BUSY poll has no timeout; it loops while BUSY=1.

Test Plan:
- Reset with all inputs 0: cmd_ready_o=1, m_req_valid_o=0, done_o=0, data_valid_o=0.
- addr=0x123456, len=0, peripheral model always ready, 1-cycle response: write sequence CLKDIV=4, CS=0, TX 0x03, 0x12, 0x34, 0x56 (each followed by BUSY polls), then CS=1. done_o pulses once, data_valid_o never asserts.
- addr=0x000100, len=3, SPI-flash model returns 0xA5, 0x5A, 0xFF: output stream A5, 5A, FF in order; 7 TX writes total; done_o pulses after the CS=1 response.
- Same as the previous case with data_ready_i low for 10 cycles on byte 2: data_o holds 0x5A stable, no m_req_valid_o during the stall, no byte lost or duplicated.
- m_req_ready_i deasserted for 5 cycles on the CS=0 write: m_req_addr_o=BASE+0x08, value 0, and wstrb F held stable the whole time; the request is issued exactly once.
- rst_i asserted while in POLL during a len=4 command: m_req_valid_o drops asynchronously, cmd_ready_o=1. A subsequent len=1 command completes normally.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Bus-master sequencer that drives an SPI peripheral's register block to run
//   SPI-flash READ (0x03) transactions and streams the returned bytes out.
//
// Ports
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o        command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_len_i          24-bit flash address, byte count (0 allowed)
//   data_valid_o/data_o/data_ready_i  returned-byte stream
//   done_o                         one-cycle pulse after CS is released
//   busy_o                         high whenever a command is in progress
//   m_req_*                        register-bus request (one outstanding max)
//   m_resp_valid_i/m_resp_value_i  register-bus response
module spi_flash_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [15:0] CLK_DIV   = 16'd4,
  parameter int          LEN_W     = 16,
  parameter int          SETTLE    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [23:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             data_valid_o,
  output logic [7:0]       data_o,
  input  logic             data_ready_i,
  output logic             done_o,
  output logic             busy_o,
  output logic             m_req_valid_o,
  output logic [31:0]      m_req_addr_o,
  output logic [31:0]      m_req_value_o,
  output logic [3:0]       m_req_wstrb_o,
  input  logic             m_req_ready_i,
  input  logic             m_resp_valid_i,
  input  logic [31:0]      m_resp_value_i
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_DIV, S_CS_LOW, S_TX_WR, S_SETTLE,
    S_POLL, S_RX_RD, S_OUT, S_CS_HIGH, S_DONE
  } state_t;

  state_t           state_q;
  logic [31:0]      hdr_q;        // remaining header bytes, MSB first
  logic [2:0]       hdr_left_q;   // header bytes not yet written to TX
  logic             was_hdr_q;    // last TX write carried a header byte
  logic [LEN_W-1:0] rem_q;        // data bytes still to be delivered
  logic [SW-1:0]    settle_q;
  logic             req_valid_q;
  logic [31:0]      req_addr_q;
  logic [31:0]      req_value_q;
  logic [3:0]       req_wstrb_q;
  logic             wait_q;       // request accepted, response outstanding
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             done_q;
  logic             busy_q;
  logic             cmd_ready_q;

  // Register access belonging to the current state
  logic             is_bus_d;
  logic [7:0]       off_d;
  logic [31:0]      wdata_d;
  logic             write_d;
  logic             bus_done;
  logic             unused_resp;

  assign unused_resp = ^m_resp_value_i[31:8];

  always_comb begin
    is_bus_d = 1'b1;
    off_d    = 8'h00;
    wdata_d  = 32'h0;
    write_d  = 1'b0;
    case (state_q)
      S_SET_DIV: begin off_d = 8'h0C; wdata_d = {16'h0, CLK_DIV}; write_d = 1'b1; end
      S_CS_LOW:  begin off_d = 8'h08; write_d = 1'b1; end
      S_TX_WR: begin
        off_d   = 8'h00;
        wdata_d = {24'h0, (hdr_left_q != 3'd0) ? hdr_q[31:24] : 8'h00};
        write_d = 1'b1;
      end
      S_POLL:    off_d = 8'h10;
      S_RX_RD:   off_d = 8'h04;
      S_CS_HIGH: begin off_d = 8'h08; wdata_d = 32'h1; write_d = 1'b1; end
      default:   is_bus_d = 1'b0;
    endcase
  end

  // Response may coincide with the accept or follow it later
  assign bus_done = (req_valid_q && m_req_ready_i && m_resp_valid_i) ||
                    (wait_q && m_resp_valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      hdr_q        <= 32'h0;
      hdr_left_q   <= 3'd0;
      was_hdr_q    <= 1'b0;
      rem_q        <= '0;
      settle_q     <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= 32'h0;
      req_value_q  <= 32'h0;
      req_wstrb_q  <= 4'h0;
      wait_q       <= 1'b0;
      data_q       <= 8'h0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      // Bus engine: issue once per state visit, hold until accepted, then
      // wait for the response. A completed access with no state change
      // (BUSY still set) simply issues again on the next cycle.
      if (is_bus_d) begin
        if (!req_valid_q && !wait_q) begin
          req_valid_q <= 1'b1;
          req_addr_q  <= BASE_ADDR + {24'h0, off_d};
          req_value_q <= wdata_d;
          req_wstrb_q <= write_d ? 4'hF : 4'h0;
        end else if (req_valid_q && m_req_ready_i) begin
          req_valid_q <= 1'b0;
          wait_q      <= !m_resp_valid_i;
        end else if (wait_q && m_resp_valid_i) begin
          wait_q <= 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            hdr_q       <= {8'h03, cmd_addr_i};
            hdr_left_q  <= 3'd4;
            rem_q       <= cmd_len_i;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_SET_DIV;
          end
        end
        S_SET_DIV: if (bus_done) state_q <= S_CS_LOW;
        S_CS_LOW:  if (bus_done) state_q <= S_TX_WR;
        S_TX_WR: begin
          if (bus_done) begin
            was_hdr_q <= (hdr_left_q != 3'd0);
            if (hdr_left_q != 3'd0) begin
              hdr_q      <= {hdr_q[23:0], 8'h00};
              hdr_left_q <= hdr_left_q - 3'd1;
            end
            settle_q <= SW'(SETTLE);
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q <= SW'(1)) state_q <= S_POLL;
          else                    settle_q <= settle_q - SW'(1);
        end
        S_POLL: begin
          if (bus_done && !m_resp_value_i[0]) begin
            if (!was_hdr_q)                state_q <= S_RX_RD;
            else if (hdr_left_q != 3'd0)   state_q <= S_TX_WR;
            else if (rem_q == '0)          state_q <= S_CS_HIGH;
            else                           state_q <= S_TX_WR;
          end
        end
        S_RX_RD: begin
          if (bus_done) begin
            data_q       <= m_resp_value_i[7:0];
            data_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end
        end
        S_OUT: begin
          if (data_ready_i) begin
            data_valid_q <= 1'b0;
            rem_q        <= rem_q - LEN_W'(1);
            state_q      <= (rem_q == LEN_W'(1)) ? S_CS_HIGH : S_TX_WR;
          end
        end
        S_CS_HIGH: begin
          if (bus_done) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign data_valid_o  = data_valid_q;
  assign data_o        = data_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign m_req_valid_o = req_valid_q;
  assign m_req_addr_o  = req_addr_q;
  assign m_req_value_o = req_value_q;
  assign m_req_wstrb_o = req_wstrb_q;

endmodule
